// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the dual-issue instruction fetch queue.
package inst_fetch_queue_pkg;

   localparam int unsigned FETCH_QUEUE_DEPTH = 8;
   localparam int unsigned XLEN              = 32;

   typedef logic [XLEN-1:0] InstAddr_t;
   typedef logic [XLEN-1:0] Inst_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] code;
   } ExceptInfo_t;

   typedef struct packed {
      InstAddr_t   pc;
      Inst_t       inst;
      ExceptInfo_t except;
   } FetchEntry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-push / decode-issue bundle between IF, the fetch queue and ID.
interface inst_fetch_queue_if
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) ();
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              flush;
   logic              push_valid;
   InstAddr_t         push_pc;
   Inst_t             push_inst1;
   Inst_t             push_inst2;
   logic              push_inst2_avail;
   ExceptInfo_t       push_except;
   logic              push_ready;
   logic [1:0]        pop_num;
   logic              out_valid1;
   logic              out_valid2;
   InstAddr_t         out_pc1;
   InstAddr_t         out_pc2;
   Inst_t             out_inst1;
   Inst_t             out_inst2;
   ExceptInfo_t       out_except1;
   ExceptInfo_t       out_except2;
   logic [CNT_W-1:0]  count;

   modport slave (
      input  flush, push_valid, push_pc, push_inst1, push_inst2, push_inst2_avail,
             push_except, pop_num,
      output push_ready, out_valid1, out_valid2, out_pc1, out_pc2, out_inst1,
             out_inst2, out_except1, out_except2, count
   );

   modport master (
      output flush, push_valid, push_pc, push_inst1, push_inst2, push_inst2_avail,
             push_except, pop_num,
      input  push_ready, out_valid1, out_valid2, out_pc1, out_pc2, out_inst1,
             out_inst2, out_except1, out_except2, count
   );
endinterface

// File: rtl/inst_fetch_queue_ram.sv
// Entry storage: two synchronous write ports, two combinational read ports.
module inst_fetch_queue_ram
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we0_i,
   input  logic [$clog2(DEPTH)-1:0] waddr0_i,
   input  FetchEntry_t              wdata0_i,
   input  logic                     we1_i,
   input  logic [$clog2(DEPTH)-1:0] waddr1_i,
   input  FetchEntry_t              wdata1_i,
   input  logic [$clog2(DEPTH)-1:0] raddr0_i,
   input  logic [$clog2(DEPTH)-1:0] raddr1_i,
   output FetchEntry_t              rdata0_o,
   output FetchEntry_t              rdata1_o
);
   FetchEntry_t mem_q [DEPTH];

   // Write ports never collide: port 1 always targets port 0's address + 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         if (we0_i) mem_q[waddr0_i] <= wdata0_i;
         if (we1_i) mem_q[waddr1_i] <= wdata1_i;
      end
   end

   assign rdata0_o = mem_q[raddr0_i];
   assign rdata1_o = mem_q[raddr1_i];
endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction queue between IF and ID: push 0-2 words, issue oldest pair,
// ID reports how many it consumed.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
   input logic               clk,
   input logic               rst,
   inst_fetch_queue_if.slave bus_io
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] push_n, pop_req, pop_n;
   logic             push_ready_c, push_acc_c, we0, we1;
   FetchEntry_t      wdata0, wdata1, rdata0, rdata1;
   logic             valid1_c, valid2_c;

   inst_fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
      .clk      (clk),
      .rst      (rst),
      .we0_i    (we0),
      .waddr0_i (tail_q),
      .wdata0_i (wdata0),
      .we1_i    (we1),
      .waddr1_i (tail_q + PTR_W'(1)),
      .wdata1_i (wdata1),
      .raddr0_i (head_q),
      .raddr1_i (head_q + PTR_W'(1)),
      .rdata0_o (rdata0),
      .rdata1_o (rdata1)
   );

   // Pointer/count next-state; flush wins over any same-cycle push or pop.
   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      push_ready_c = (count_q <= CNT_W'(DEPTH - 2));
      push_acc_c   = bus_io.push_valid & push_ready_c & ~bus_io.flush;
      we0          = push_acc_c;
      we1          = push_acc_c & bus_io.push_inst2_avail;
      push_n       = CNT_W'(we0) + CNT_W'(we1);
      pop_req      = CNT_W'(bus_io.pop_num);
      pop_n        = (pop_req > count_q) ? count_q : pop_req;
      wdata0       = '{pc: bus_io.push_pc, inst: bus_io.push_inst1, except: bus_io.push_except};
      wdata1       = '{pc: bus_io.push_pc + 32'd4, inst: bus_io.push_inst2, except: '0};
      if (bus_io.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PTR_W'(pop_n);
         tail_d  = tail_q + PTR_W'(push_n);
         count_d = count_q + push_n - pop_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // An excepting head instruction issues alone; absent slots read as zero.
   always_comb begin
      valid1_c = (count_q != '0);
      valid2_c = (count_q >= CNT_W'(2)) & ~rdata0.except.valid;
   end

   assign bus_io.push_ready  = push_ready_c;
   assign bus_io.count       = count_q;
   assign bus_io.out_valid1  = valid1_c;
   assign bus_io.out_valid2  = valid2_c;
   assign bus_io.out_pc1     = valid1_c ? rdata0.pc     : '0;
   assign bus_io.out_inst1   = valid1_c ? rdata0.inst   : '0;
   assign bus_io.out_except1 = valid1_c ? rdata0.except : '0;
   assign bus_io.out_pc2     = valid2_c ? rdata1.pc     : '0;
   assign bus_io.out_inst2   = valid2_c ? rdata1.inst   : '0;
   assign bus_io.out_except2 = valid2_c ? rdata1.except : '0;

   a_pop_legal : assert property (@(posedge clk) disable iff (rst)
      (bus_io.pop_num != 2'd3) && (CNT_W'(bus_io.pop_num) <= count_q));
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus randomized traffic vs a queue model.
module tb_inst_fetch_queue;
   import inst_fetch_queue_pkg::*;

   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   FetchEntry_t mq[$];

   inst_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

   inst_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic idle();
      bus.flush            = 1'b0;
      bus.push_valid       = 1'b0;
      bus.push_pc          = '0;
      bus.push_inst1       = '0;
      bus.push_inst2       = '0;
      bus.push_inst2_avail = 1'b0;
      bus.push_except      = '0;
      bus.pop_num          = 2'd0;
   endtask

   // Advance one clock, apply the queue semantics to the model, return inputs to idle.
   task automatic tick();
      int          popn;
      bit          rdy;
      FetchEntry_t e;
      @(posedge clk);
      if (rst || bus.flush) begin
         mq.delete();
      end else begin
         rdy  = (int'(DEPTH) - mq.size()) >= 2;
         popn = (int'(bus.pop_num) > mq.size()) ? mq.size() : int'(bus.pop_num);
         for (int i = 0; i < popn; i++) void'(mq.pop_front());
         if (bus.push_valid && rdy) begin
            e = '{pc: bus.push_pc, inst: bus.push_inst1, except: bus.push_except};
            mq.push_back(e);
            if (bus.push_inst2_avail) begin
               e = '{pc: bus.push_pc + 32'd4, inst: bus.push_inst2, except: '0};
               mq.push_back(e);
            end
         end
      end
      #1;
      idle();
   endtask

   task automatic do_push(input logic [31:0] pc, input bit two);
      bus.push_valid       = 1'b1;
      bus.push_pc          = pc;
      bus.push_inst1       = pc ^ 32'h2400_0000;
      bus.push_inst2       = (pc + 32'd4) ^ 32'h2400_0000;
      bus.push_inst2_avail = two;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
      checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b exp 0", bus.out_valid1); end
      checks++; if (bus.push_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.push_ready); end
      checks++; if (bus.out_pc1 !== 32'h0) begin errors++; $display("FAIL reset_pc1 got %h exp 0", bus.out_pc1); end
   endtask

   task automatic test_basic_pair();
      bus.push_valid = 1'b1; bus.push_pc = 32'h8000_0000;
      bus.push_inst1 = 32'h2401_0001; bus.push_inst2 = 32'h2402_0002; bus.push_inst2_avail = 1'b1;
      tick();
      checks++; if (bus.out_pc1 !== 32'h8000_0000) begin errors++; $display("FAIL pair_pc1 got %h exp 80000000", bus.out_pc1); end
      checks++; if (bus.out_pc2 !== 32'h8000_0004) begin errors++; $display("FAIL pair_pc2 got %h exp 80000004", bus.out_pc2); end
      checks++; if (bus.out_inst2 !== 32'h2402_0002) begin errors++; $display("FAIL pair_inst2 got %h exp 24020002", bus.out_inst2); end
      checks++; if (bus.out_valid2 !== 1'b1) begin errors++; $display("FAIL pair_valid2 got %b exp 1", bus.out_valid2); end
      checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL pair_count got %0d exp 2", bus.count); end
   endtask

   task automatic test_pop_push();
      bus.pop_num = 2'd1;
      bus.push_valid = 1'b1; bus.push_pc = 32'h8000_0008;
      bus.push_inst1 = 32'h2403_0003; bus.push_inst2_avail = 1'b0;
      tick();
      checks++; if (bus.out_pc1 !== 32'h8000_0004) begin errors++; $display("FAIL poppush_pc1 got %h exp 80000004", bus.out_pc1); end
      checks++; if (bus.out_pc2 !== 32'h8000_0008) begin errors++; $display("FAIL poppush_pc2 got %h exp 80000008", bus.out_pc2); end
      checks++; if (bus.out_inst2 !== 32'h2403_0003) begin errors++; $display("FAIL poppush_inst2 got %h exp 24030003", bus.out_inst2); end
      checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL poppush_count got %0d exp 2", bus.count); end
   endtask

   task automatic test_full();
      logic [31:0] pc = 32'h8000_0100;
      while (mq.size() <= 5) begin do_push(pc, 1'b1); pc += 8; tick(); end
      if (mq.size() == 6) begin do_push(pc, 1'b0); pc += 4; tick(); end
      checks++; if (bus.count !== 4'd7) begin errors++; $display("FAIL full_count got %0d exp 7", bus.count); end
      checks++; if (bus.push_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.push_ready); end
      do_push(pc, 1'b1);
      tick();
      checks++; if (bus.count !== 4'd7) begin errors++; $display("FAIL full_drop got %0d exp 7", bus.count); end
      bus.pop_num = 2'd2;
      tick();
      checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL full_pop_count got %0d exp 5", bus.count); end
      checks++; if (bus.push_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %b exp 1", bus.push_ready); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc;
      do_reset();
      for (int i = 0; i < 3; i++) begin do_push(32'h1000_0000 + 32'(i * 8), 1'b1); tick(); end
      do_push(32'h1000_0018, 1'b0); tick();
      while (mq.size() > 0) begin bus.pop_num = (mq.size() >= 2) ? 2'd2 : 2'd1; tick(); end
      // tail now sits at DEPTH-1
      do_push(32'h9000_0000, 1'b1); tick();
      do_push(32'h9000_0008, 1'b1); tick();
      exp_pc = 32'h9000_0000;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.out_pc1 !== exp_pc) begin errors++; $display("FAIL wrap_order[%0d] got %h exp %h", i, bus.out_pc1, exp_pc); end
         exp_pc += 4;
         bus.pop_num = 2'd1;
         tick();
      end
      checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b exp 0", bus.out_valid1); end
   endtask

   task automatic test_except();
      do_reset();
      do_push(32'h8000_0200, 1'b1);
      bus.push_except = '{valid: 1'b1, code: 5'd6};
      tick();
      checks++; if (bus.out_valid1 !== 1'b1) begin errors++; $display("FAIL exc_valid1 got %b exp 1", bus.out_valid1); end
      checks++; if (bus.out_valid2 !== 1'b0) begin errors++; $display("FAIL exc_valid2 got %b exp 0", bus.out_valid2); end
      checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL exc_count got %0d exp 2", bus.count); end
      checks++; if (bus.out_except1 !== 6'b1_00110) begin errors++; $display("FAIL exc_info1 got %h exp 26", bus.out_except1); end
      bus.pop_num = 2'd1;
      tick();
      checks++; if (bus.out_except1 !== 6'd0) begin errors++; $display("FAIL exc_next_info got %h exp 0", bus.out_except1); end
      checks++; if (bus.out_pc1 !== 32'h8000_0204) begin errors++; $display("FAIL exc_next_pc got %h exp 80000204", bus.out_pc1); end
   endtask

   task automatic test_flush();
      do_reset();
      do_push(32'h8000_0300, 1'b1); tick();
      do_push(32'h8000_0308, 1'b1); tick();
      checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL flush_pre_count got %0d exp 4", bus.count); end
      do_push(32'h8000_0310, 1'b1);
      bus.pop_num = 2'd2;
      bus.flush   = 1'b1;
      tick();
      checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", bus.count); end
      checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL flush_valid1 got %b exp 0", bus.out_valid1); end
   endtask

   task automatic test_reset_mid();
      do_push(32'h8000_0400, 1'b1); tick();
      do_push(32'h8000_0408, 1'b1); tick();
      do_push(32'h8000_0410, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", bus.count); end
      checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL rstmid_valid1 got %b exp 0", bus.out_valid1); end
      checks++; if (bus.out_pc1 !== 32'h0) begin errors++; $display("FAIL rstmid_pc1 got %h exp 0", bus.out_pc1); end
      checks++; if (bus.push_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", bus.push_ready); end
   endtask

   task automatic test_random();
      bit          ev1, ev2;
      FetchEntry_t e1, e2;
      int          maxpop;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         bus.push_valid       = ($urandom_range(0, 3) != 0);
         bus.push_pc          = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
         bus.push_inst1       = $urandom;
         bus.push_inst2       = $urandom;
         bus.push_inst2_avail = $urandom_range(0, 1) != 0;
         bus.push_except      = ($urandom_range(0, 7) == 0) ? '{valid: 1'b1, code: 5'($urandom_range(0, 31))} : '0;
         maxpop               = (mq.size() > 2) ? 2 : mq.size();
         bus.pop_num          = 2'($urandom_range(0, maxpop));
         bus.flush            = ($urandom_range(0, 31) == 0);
         tick();
         ev1 = mq.size() >= 1;
         ev2 = (mq.size() >= 2) && !mq[0].except.valid;
         e1  = ev1 ? mq[0] : '0;
         e2  = ev2 ? mq[1] : '0;
         checks++; if (bus.count !== 4'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", n, bus.count, mq.size()); end
         checks++; if (bus.push_ready !== ((int'(DEPTH) - mq.size()) >= 2)) begin errors++; $display("FAIL rnd_ready[%0d] got %b", n, bus.push_ready); end
         checks++; if (bus.out_valid1 !== ev1 || bus.out_valid2 !== ev2) begin errors++; $display("FAIL rnd_valid[%0d] got %b%b exp %b%b", n, bus.out_valid1, bus.out_valid2, ev1, ev2); end
         checks++; if ({bus.out_pc1, bus.out_inst1, bus.out_except1} !== e1) begin errors++; $display("FAIL rnd_slot1[%0d] got %h/%h exp %h/%h", n, bus.out_pc1, bus.out_inst1, e1.pc, e1.inst); end
         checks++; if ({bus.out_pc2, bus.out_inst2, bus.out_except2} !== e2) begin errors++; $display("FAIL rnd_slot2[%0d] got %h/%h exp %h/%h", n, bus.out_pc2, bus.out_inst2, e2.pc, e2.inst); end
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_basic_pair();
      test_pop_push();
      test_full();
      test_wrap();
      test_except();
      test_flush();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
